// File: rtl/cell_1.sv
// cell_1: single-bit cell of the modular multiply/divide array.
//
// Multiply mode (MUL_BAR = 0): adds the partial-product bit X_IN & Y_ROW to
// the incoming partial-sum bit P with carry-in C_CP_RP.
// Divide mode (MUL_BAR = 1): controlled add/subtract cell, adding Y_ROW to
// X_IN ^ P (P = 1 inverts the divisor bit) with carry-in C_CP_R.
// Sum and carry are registered, so each cell adds one cycle of carry skew.
//
// Ports:
//   CLK      rising-edge clock
//   RST      synchronous active-high reset, clears OUT and C_OUT
//   Y_ROW    multiplier bit (mul) / partial-remainder bit (div)
//   X_IN     multiplicand bit (mul) / divisor bit (div)
//   P        partial-sum bit (mul) / subtract control (div)
//   MUL_BAR  0 = multiply, 1 = divide
//   C_CP_R   carry-in used in divide mode
//   C_CP_RP  carry-in used in multiply mode
//   C_OUT    registered carry-out
//   OUT      registered sum bit
module cell_1 (
  input  logic CLK,
  input  logic RST,
  input  logic Y_ROW,
  input  logic X_IN,
  input  logic P,
  input  logic MUL_BAR,
  input  logic C_CP_R,
  input  logic C_CP_RP,
  output logic C_OUT,
  output logic OUT
);

  logic op_a, op_b, carry_in;
  logic sum_d, sum_q;
  logic cout_d, cout_q;

  // Operand selection; the unused carry-in of each mode is ignored.
  always_comb begin
    op_a     = 1'b0;
    op_b     = 1'b0;
    carry_in = 1'b0;
    if (MUL_BAR) begin
      op_a     = Y_ROW;
      op_b     = X_IN ^ P;
      carry_in = C_CP_R;
    end else begin
      op_a     = X_IN & Y_ROW;
      op_b     = P;
      carry_in = C_CP_RP;
    end
  end

  // Full adder.
  always_comb begin
    sum_d  = op_a ^ op_b ^ carry_in;
    cout_d = (op_a & op_b) | (op_a & carry_in) | (op_b & carry_in);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign OUT   = sum_q;
  assign C_OUT = cout_q;

endmodule

// File: tb/tb_cell_1.sv
// Self-checking bench for cell_1: directed vectors from the test plan, an
// exhaustive sweep of all 64 input combinations, then randomized vectors with
// occasional resets, all compared against an arithmetic reference model.
module tb_cell_1;

  logic clk = 1'b0;
  logic rst;
  logic y_row, x_in, p, mul_bar, c_cp_r, c_cp_rp;
  logic c_out, out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cell_1 dut (
    .CLK     (clk),
    .RST     (rst),
    .Y_ROW   (y_row),
    .X_IN    (x_in),
    .P       (p),
    .MUL_BAR (mul_bar),
    .C_CP_R  (c_cp_r),
    .C_CP_RP (c_cp_rp),
    .C_OUT   (c_out),
    .OUT     (out)
  );

  // Vector bit order: {MUL_BAR, Y_ROW, X_IN, P, C_CP_R, C_CP_RP}.
  // Result order: {carry, sum}, i.e. the 2-bit arithmetic total a + b + cin.
  function automatic logic [1:0] model(input logic [5:0] v, input logic r);
    int a, b, c;
    if (r) return 2'b00;
    if (v[5]) begin
      a = int'(v[4]);
      b = int'(v[3] ^ v[2]);
      c = int'(v[1]);
    end else begin
      a = int'(v[4] & v[3]);
      b = int'(v[2]);
      c = int'(v[0]);
    end
    return 2'(a + b + c);
  endfunction

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {C_OUT,OUT}=%b expected %b", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, check just after the capture edge, then check
  // again later in the cycle that the outputs held.
  task automatic step(input string tag, input logic [5:0] v, input logic r,
                      input logic [1:0] exp);
    @(negedge clk);
    rst = r;
    {mul_bar, y_row, x_in, p, c_cp_r, c_cp_rp} = v;
    @(posedge clk);
    #1;
    check(tag, {c_out, out}, exp);
    #3;
    check({tag, "_hold"}, {c_out, out}, exp);
  endtask

  initial begin
    logic [5:0] v;
    logic       r;
    rst = 1'b1;
    {mul_bar, y_row, x_in, p, c_cp_r, c_cp_rp} = '0;

    // Reset with every input high.
    step("reset", 6'b111111, 1'b1, 2'b00);
    step("reset2", 6'b011111, 1'b1, 2'b00);

    // Multiply.
    step("mul_xy", 6'b011000, 1'b0, 2'b01);
    step("mul_x0", 6'b010000, 1'b0, 2'b00);
    step("mul_crp", 6'b011001, 1'b0, 2'b10);
    step("mul_p_crp", 6'b011101, 1'b0, 2'b11);
    step("mul_cr_ign", 6'b011111, 1'b0, 2'b11);
    step("mul_cr_ign0", 6'b011010, 1'b0, 2'b01);

    // Divide.
    step("div_sub", 6'b111100, 1'b0, 2'b01);
    step("div_add_cr", 6'b111010, 1'b0, 2'b11);
    step("div_crp_ign", 6'b111011, 1'b0, 2'b11);
    step("div_crp_ign0", 6'b111101, 1'b0, 2'b01);

    // Reset mid-operation discards the result, next edge computes again.
    step("mid_rst", 6'b111010, 1'b1, 2'b00);
    step("post_rst", 6'b111010, 1'b0, 2'b11);

    // Exhaustive sweep.
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      step("exh", v, 1'b0, model(v, 1'b0));
    end

    // Randomized vectors with occasional resets.
    for (int i = 0; i < 300; i++) begin
      v = 6'($urandom_range(0, 63));
      r = ($urandom_range(0, 15) == 0);
      step("rand", v, r, model(v, r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
